ts_packet_arbiter: RTL and testbench

Packet-level arbiter placed after the four per-stream sync-recovery channels. It takes the four byte-aligned 188-byte MPEG-2 TS streams and forwards whole packets from one stream at a time onto a single output byte bus, in round-robin order. Packets that arrive while another packet is being forwarded are dropped and counted. Packets whose input stalls or loses sync partway through are aborted.

---
 rtl/ts_packet_arbiter_if.sv | 33 +++
 rtl/ts_packet_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ts_packet_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ts_packet_arbiter_if.sv
// Byte-stream bus between the four sync-recovery channels and the packet arbiter.
// The drop_cnt signal exists only when TS_ARB_DROP_CNT_EN is defined.
interface ts_packet_arbiter_if;
  logic [31:0] ts_in;
  logic [3:0]  ts_in_valid;
  logic [3:0]  ts_in_sop;
  logic [3:0]  chan_en;
  logic [7:0]  ts_out;
  logic        ts_out_valid;
  logic        ts_out_sop;
  logic        ts_out_eop;
  logic [1:0]  ts_out_chan;
  logic        pkt_abort;
`ifdef TS_ARB_DROP_CNT_EN
  logic [63:0] drop_cnt;
`endif

  modport master (
    output ts_in, ts_in_valid, ts_in_sop, chan_en,
    input  ts_out, ts_out_valid, ts_out_sop, ts_out_eop, ts_out_chan, pkt_abort
`ifdef TS_ARB_DROP_CNT_EN
    , input drop_cnt
`endif
  );

  modport slave (
    input  ts_in, ts_in_valid, ts_in_sop, chan_en,
    output ts_out, ts_out_valid, ts_out_sop, ts_out_eop, ts_out_chan, pkt_abort
`ifdef TS_ARB_DROP_CNT_EN
    , output drop_cnt
`endif
  );
endinterface

// File: rtl/ts_packet_arbiter.sv
// Round-robin packet arbiter forwarding whole 188-byte TS packets from four streams.
// Optional per-channel saturating drop counters: define TS_ARB_DROP_CNT_EN.
//
// state | meaning
// IDLE  | waiting for an enabled channel to present a sop byte
// FWD   | forwarding the granted channel's packet until eop, stall timeout or sync slip
module ts_packet_arbiter #(
  parameter int PKT_LEN = 188,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  ts_packet_arbiter_if.slave bus
);

  localparam logic [7:0] PKT_LEN_B = 8'(PKT_LEN);
  localparam logic [7:0] TIMEOUT_B = 8'(TIMEOUT);

  typedef enum logic {IDLE, FWD} state_t;

  state_t     state, state_nxt;
  logic [1:0] last_grant, last_grant_nxt;
  logic [1:0] chan_q, chan_nxt;
  logic [7:0] byte_cnt, byte_cnt_nxt;
  logic [7:0] stall_cnt, stall_cnt_nxt;
  logic [7:0] out_q, out_nxt;
  logic       valid_q, valid_nxt;
  logic       sop_q, sop_nxt;
  logic       eop_q, eop_nxt;
  logic       abort_q, abort_nxt;

  logic [3:0] cand;
  logic       found;
  logic [1:0] gnt;
  logic [1:0] idx;
  logic       g_valid, g_sop;
  logic [7:0] g_byte;

  assign cand    = bus.chan_en & bus.ts_in_valid & bus.ts_in_sop;
  assign g_valid = bus.ts_in_valid[chan_q];
  assign g_sop   = bus.ts_in_sop[chan_q];
  assign g_byte  = bus.ts_in[{chan_q, 3'b000} +: 8];

  // Search starts one past the last winner so every channel gets a turn.
  always_comb begin
    found = 1'b0;
    gnt   = 2'd0;
    idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = last_grant + 2'(i + 1);
      if (!found && cand[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    chan_nxt       = chan_q;
    byte_cnt_nxt   = byte_cnt;
    stall_cnt_nxt  = stall_cnt;
    out_nxt        = out_q;
    valid_nxt      = 1'b0;
    sop_nxt        = 1'b0;
    eop_nxt        = 1'b0;
    abort_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          last_grant_nxt = gnt;
          chan_nxt       = gnt;
          byte_cnt_nxt   = 8'd1;
          stall_cnt_nxt  = 8'd0;
          out_nxt        = bus.ts_in[{gnt, 3'b000} +: 8];
          valid_nxt      = 1'b1;
          sop_nxt        = 1'b1;
          state_nxt      = FWD;
        end
      end
      FWD: begin
        if (g_valid && !g_sop) begin
          out_nxt       = g_byte;
          valid_nxt     = 1'b1;
          byte_cnt_nxt  = byte_cnt + 8'd1;
          stall_cnt_nxt = 8'd0;
          if (byte_cnt_nxt == PKT_LEN_B) begin
            eop_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end else if (g_valid) begin
          // Sync slip: a new sop before the packet is complete truncates it.
          abort_nxt = 1'b1;
          state_nxt = IDLE;
        end else begin
          stall_cnt_nxt = stall_cnt + 8'd1;
          if (stall_cnt_nxt == TIMEOUT_B) begin
            abort_nxt = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 2'd3;
      chan_q     <= 2'd0;
      byte_cnt   <= 8'd0;
      stall_cnt  <= 8'd0;
      out_q      <= 8'h00;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      chan_q     <= chan_nxt;
      byte_cnt   <= byte_cnt_nxt;
      stall_cnt  <= stall_cnt_nxt;
      out_q      <= out_nxt;
      valid_q    <= valid_nxt;
      sop_q      <= sop_nxt;
      eop_q      <= eop_nxt;
      abort_q    <= abort_nxt;
    end
  end

  assign bus.ts_out       = out_q;
  assign bus.ts_out_valid = valid_q;
  assign bus.ts_out_sop   = sop_q;
  assign bus.ts_out_eop   = eop_q;
  assign bus.ts_out_chan  = chan_q;
  assign bus.pkt_abort    = abort_q;

`ifdef TS_ARB_DROP_CNT_EN
  logic [3:0]  grant_mask;
  logic [3:0]  drop_inc;
  logic [15:0] drop_q [4];

  // Every enabled sop that does not win a grant this cycle is a drop, including slips.
  assign grant_mask = (state == IDLE && found) ? (4'b0001 << gnt) : 4'b0000;
  assign drop_inc   = cand & ~grant_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 4; n++) drop_q[n] <= 16'h0000;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (drop_inc[n] && drop_q[n] != 16'hFFFF) drop_q[n] <= drop_q[n] + 16'h0001;
      end
    end
  end

  assign bus.drop_cnt = {drop_q[3], drop_q[2], drop_q[1], drop_q[0]};
`endif

endmodule

// File: tb/tb_ts_packet_arbiter.sv
// Directed scoreboard bench for ts_packet_arbiter; drop counter checks apply when
// TS_ARB_DROP_CNT_EN is defined.
module tb_ts_packet_arbiter;
  localparam int PKT_LEN = 188;
  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ts_packet_arbiter_if ifc();

  ts_packet_arbiter #(.PKT_LEN(PKT_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  typedef struct packed {
    logic       valid;
    logic       sop;
    logic       eop;
    logic       abort;
    logic [1:0] chan;
    logic [7:0] data;
  } out_t;

  out_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  int   exp_drop[4] = '{0, 0, 0, 0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pkt_byte(input int k);
    return (k == 0) ? 8'h47 : 8'(k - 1);
  endfunction

  task automatic set_ch(input int ch, input logic [7:0] d, input logic v, input logic s);
    ifc.ts_in[8*ch +: 8] = d;
    ifc.ts_in_valid[ch]  = v;
    ifc.ts_in_sop[ch]    = s;
  endtask

  task automatic clear_in();
    ifc.ts_in       = '0;
    ifc.ts_in_valid = '0;
    ifc.ts_in_sop   = '0;
  endtask

  task automatic expect_byte(input int ch, input int k);
    out_t e;
    e = '{valid: 1'b1, sop: (k == 0), eop: (k == PKT_LEN - 1), abort: 1'b0,
          chan: 2'(ch), data: pkt_byte(k)};
    exp_q.push_back(e);
  endtask

  task automatic expect_abort(input int ch);
    out_t e;
    e = '{valid: 1'b0, sop: 1'b0, eop: 1'b0, abort: 1'b1, chan: 2'(ch), data: 8'h00};
    exp_q.push_back(e);
  endtask

  // One clock: outputs sampled 1 time unit after the edge and matched to the scoreboard.
  task automatic step();
    out_t o, e;
    @(posedge clk);
    #1;
    o = '{valid: ifc.ts_out_valid, sop: ifc.ts_out_sop, eop: ifc.ts_out_eop,
          abort: ifc.pkt_abort, chan: ifc.ts_out_chan, data: ifc.ts_out};
    if (exp_q.size() == 0) begin
      chk("idle_out", {62'd0, o.valid, o.abort}, 64'd0);
    end else begin
      e = exp_q.pop_front();
      if (e.abort) o.data = 8'h00;
      chk("out_beat", 64'(o), 64'(e));
    end
  endtask

  task automatic drive_bytes(input int ch, input int k0, input int k1);
    for (int k = k0; k < k1; k++) begin
      set_ch(ch, pkt_byte(k), 1'b1, k == 0);
      expect_byte(ch, k);
      step();
    end
    set_ch(ch, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic chk_drop(input string tag);
`ifdef TS_ARB_DROP_CNT_EN
    for (int n = 0; n < 4; n++) chk(tag, 64'(ifc.drop_cnt[16*n +: 16]), 64'(exp_drop[n]));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_in();
    ifc.chan_en = 4'b0000;
    rst = 1'b1;
    repeat (3) step();
    chk("reset_out", {ifc.ts_out, ifc.ts_out_chan, ifc.ts_out_sop, ifc.ts_out_eop}, 64'd0);
    chk_drop("reset_drop");
    rst = 1'b0;

    // Single channel full packet
    ifc.chan_en = 4'b0100;
    drive_bytes(2, 0, PKT_LEN);
    step();
    chk_drop("single_drop");

    // Four-way tie over four slots, shrinking set of contenders
    rst = 1'b1;
    step();
    rst = 1'b0;
    ifc.chan_en = 4'b1111;
    for (int slot = 0; slot < 4; slot++) begin
      for (int c = slot; c < 4; c++) begin
        set_ch(c, 8'h47, 1'b1, 1'b1);
        if (c != slot) exp_drop[c]++;
      end
      expect_byte(slot, 0);
      step();
      clear_in();
      if (slot == 3) begin
        drive_bytes(3, 1, PKT_LEN - 1);
        set_ch(0, 8'h47, 1'b1, 1'b1);
        exp_drop[0]++;
        drive_bytes(3, PKT_LEN - 1, PKT_LEN);
        clear_in();
      end else begin
        drive_bytes(slot, 1, PKT_LEN);
      end
    end
    step();
    chk_drop("tie_drop");

    // Stall one short of timeout survives, a full timeout aborts
    drive_bytes(0, 0, 20);
    repeat (TIMEOUT - 1) step();
    drive_bytes(0, 20, 50);
    for (int i = 0; i < TIMEOUT; i++) begin
      if (i == TIMEOUT - 1) expect_abort(0);
      step();
    end
    step();
    drive_bytes(0, 0, PKT_LEN);
    step();

    // Sync slip at byte 100 on channel 1
    drive_bytes(1, 0, 99);
    set_ch(1, 8'h47, 1'b1, 1'b1);
    expect_abort(1);
    exp_drop[1]++;
    step();
    set_ch(1, 8'h00, 1'b0, 1'b0);
    step();
    chk_drop("slip_drop");

    // Disabled channel is ignored; disabling the granted channel mid-packet is harmless
    ifc.chan_en = 4'b1011;
    for (int k = 0; k < PKT_LEN; k++) begin
      set_ch(2, pkt_byte(k), 1'b1, k == 0);
      step();
    end
    set_ch(2, 8'h00, 1'b0, 1'b0);
    step();
    chk_drop("disabled_drop");
    ifc.chan_en = 4'b1111;
    drive_bytes(3, 0, 60);
    ifc.chan_en = 4'b0000;
    drive_bytes(3, 60, PKT_LEN);
    step();
    ifc.chan_en = 4'b1111;

    // Reset in the middle of a packet
    drive_bytes(0, 0, 119);
    set_ch(0, pkt_byte(119), 1'b1, 1'b0);
    rst = 1'b1;
    step();
    exp_drop = '{0, 0, 0, 0};
    chk("midreset_out", {ifc.ts_out, ifc.ts_out_chan, ifc.ts_out_sop, ifc.ts_out_eop}, 64'd0);
    chk_drop("midreset_drop");
    rst = 1'b0;
    clear_in();
    step();
    for (int c = 0; c < 4; c++) begin
      set_ch(c, 8'h47, 1'b1, 1'b1);
      if (c != 0) exp_drop[c]++;
    end
    expect_byte(0, 0);
    step();
    clear_in();
    drive_bytes(0, 1, PKT_LEN);
    step();
    chk_drop("post_reset_drop");
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
